cb_branch: RTL and testbench

Synchronous, clocked implementation of the DDP branch element (CB). It accepts one token per handshake from an upstream stage and routes it to output branch a or branch b according to `Br`. It issues a one-cycle capture pulse (`CB_CP`) so the data register latches the token. It acknowledges upstream only after the selected downstream stage has acknowledged. It sits between an upstream pipeline stage and two downstream `c_stage` pipeline stages.

---
 rtl/ddp_hs_pkg.sv | 20 ++
 rtl/cb_branch_if.sv | 36 +++
 rtl/c_stage.sv | 65 ++++++
 rtl/cb_branch.sv | 59 +++++
 tb/tb_cb_branch.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddp_hs_pkg.sv
// Shared definitions for the DDP handshake elements: stage states,
// active-low handshake levels and the falling-edge event test.
package ddp_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } hs_state_e;

  localparam logic HS_IDLE   = 1'b1;
  localparam logic HS_ACTIVE = 1'b0;

  // A handshake event is a high-to-low transition between two samples.
  function automatic logic hs_event(input logic prev, input logic cur);
    return (prev == HS_IDLE) && (cur == HS_ACTIVE);
  endfunction

endpackage

// File: rtl/cb_branch_if.sv
// Handshake bundle between the upstream stage, the branch element and
// the two downstream branches.
interface cb_branch_if;

  logic CB_Send_in;
  logic Br;
  logic CB_Ack_in_a;
  logic CB_Ack_in_b;
  logic CB_Ack_out;
  logic CB_Send_out_a;
  logic CB_Send_out_b;
  logic CB_CP;

  modport master (
    output CB_Send_in,
    output Br,
    output CB_Ack_in_a,
    output CB_Ack_in_b,
    input  CB_Ack_out,
    input  CB_Send_out_a,
    input  CB_Send_out_b,
    input  CB_CP
  );

  modport slave (
    input  CB_Send_in,
    input  Br,
    input  CB_Ack_in_a,
    input  CB_Ack_in_b,
    output CB_Ack_out,
    output CB_Send_out_a,
    output CB_Send_out_b,
    output CB_CP
  );

endinterface

// File: rtl/c_stage.sv
// One-slot DDP pipeline stage: request edge -> capture + send pulse,
// wait for downstream ack, then acknowledge upstream.
module c_stage
  import ddp_hs_pkg::*;
(
  input  logic CLK,
  input  logic MR,
  input  logic Send_in,
  input  logic Ack_in,
  output logic Ack_out,
  output logic Send_out,
  output logic CP
);

  hs_state_e state;
  logic      send_prev;
  logic      ack_prev;
  logic      send_ev;
  logic      ack_ev;

  assign send_ev = hs_event(send_prev, Send_in);
  assign ack_ev  = hs_event(ack_prev, Ack_in);

  // Previous-sample registers reset high so a line held low at reset
  // release counts as an event on the first edge.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      state     <= IDLE;
      send_prev <= HS_IDLE;
      ack_prev  <= HS_IDLE;
      Ack_out   <= HS_IDLE;
      Send_out  <= HS_IDLE;
      CP        <= 1'b0;
    end else begin
      send_prev <= Send_in;
      ack_prev  <= Ack_in;
      case (state)
        IDLE: begin
          if (send_ev) begin
            state    <= FIRE;
            CP       <= 1'b1;
            Send_out <= HS_ACTIVE;
          end
        end
        FIRE: begin
          state    <= WAIT;
          CP       <= 1'b0;
          Send_out <= HS_IDLE;
        end
        WAIT: begin
          if (ack_ev) begin
            state   <= DONE;
            Ack_out <= HS_ACTIVE;
          end
        end
        DONE: begin
          state   <= IDLE;
          Ack_out <= HS_IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cb_branch.sv
// DDP branch element: one c_stage slot whose send pulse is steered to
// branch a or b by the select latched on the request edge.
module cb_branch
  import ddp_hs_pkg::*;
(
  input  logic        CLK,
  input  logic        MR,
  cb_branch_if.slave  bus
);

  logic sel;
  logic busy;
  logic send_prev;
  logic send_ev;
  logic stage_ack_in;
  logic stage_ack_out;
  logic stage_send_out;
  logic stage_cp;

  assign send_ev = hs_event(send_prev, bus.CB_Send_in);

  // Only the selected branch's ack reaches the slot; the slot itself
  // ignores ack transitions until it is waiting.
  assign stage_ack_in = sel ? bus.CB_Ack_in_b : bus.CB_Ack_in_a;

  c_stage u_stage (
    .CLK      (CLK),
    .MR       (MR),
    .Send_in  (bus.CB_Send_in),
    .Ack_in   (stage_ack_in),
    .Ack_out  (stage_ack_out),
    .Send_out (stage_send_out),
    .CP       (stage_cp)
  );

  // busy mirrors the slot being outside IDLE, so Br is only captured on
  // a request the slot actually accepts.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      sel       <= 1'b0;
      busy      <= 1'b0;
      send_prev <= HS_IDLE;
    end else begin
      send_prev <= bus.CB_Send_in;
      if (!busy && send_ev) begin
        busy <= 1'b1;
        sel  <= bus.Br;
      end else if (busy && (stage_ack_out == HS_ACTIVE)) begin
        busy <= 1'b0;
      end
    end
  end

  assign bus.CB_CP         = stage_cp;
  assign bus.CB_Ack_out    = stage_ack_out;
  assign bus.CB_Send_out_a = sel ? HS_IDLE : stage_send_out;
  assign bus.CB_Send_out_b = sel ? stage_send_out : HS_IDLE;

endmodule

// File: tb/tb_cb_branch.sv
// Bench for cb_branch: directed handshake scenarios, randomized windows
// against an event-level reference model, and a chain with two c_stages.
module tb_cb_branch;

  localparam int MAXL = 128;

  logic CLK = 1'b0;
  logic MR  = 1'b0;
  logic send_drv = 1'b1;
  logic br_drv   = 1'b0;
  logic aa_drv   = 1'b1;
  logic ab_drv   = 1'b1;
  logic chain_mode = 1'b0;
  logic sink_a = 1'b1;
  logic sink_b = 1'b1;
  logic sa_ack, sa_send, sa_cp;
  logic sb_ack, sb_send, sb_cp;

  int vectors = 0;
  int miscompares = 0;

  bit   w_send [MAXL];
  bit   w_br   [MAXL];
  bit   w_aa   [MAXL];
  bit   w_ab   [MAXL];
  bit   x_cp   [MAXL];
  bit   x_sa   [MAXL];
  bit   x_sb   [MAXL];
  bit   x_ack  [MAXL];
  logic o_cp   [MAXL];
  logic o_sa   [MAXL];
  logic o_sb   [MAXL];
  logic o_ack  [MAXL];

  cb_branch_if bus ();

  assign bus.CB_Send_in  = send_drv;
  assign bus.Br          = br_drv;
  assign bus.CB_Ack_in_a = chain_mode ? sa_ack : aa_drv;
  assign bus.CB_Ack_in_b = chain_mode ? sb_ack : ab_drv;

  cb_branch dut (
    .CLK (CLK),
    .MR  (MR),
    .bus (bus)
  );

  c_stage u_sa (
    .CLK (CLK), .MR (MR), .Send_in (bus.CB_Send_out_a), .Ack_in (sink_a),
    .Ack_out (sa_ack), .Send_out (sa_send), .CP (sa_cp)
  );

  c_stage u_sb (
    .CLK (CLK), .MR (MR), .Send_in (bus.CB_Send_out_b), .Ack_in (sink_b),
    .Ack_out (sb_ack), .Send_out (sb_send), .CP (sb_cp)
  );

  always #5 CLK = ~CLK;

  task automatic clear_wave(input int L);
    for (int k = 0; k < L; k++) begin
      w_send[k] = 1'b1; w_br[k] = 1'b0; w_aa[k] = 1'b1; w_ab[k] = 1'b1;
    end
  endtask

  // w[k] is driven during cycle k; outputs of cycle k are stored in o[k].
  task automatic apply_window(input int L);
    for (int k = 0; k < L; k++) begin
      @(posedge CLK); #1;
      send_drv = w_send[k]; br_drv = w_br[k]; aa_drv = w_aa[k]; ab_drv = w_ab[k];
      @(negedge CLK);
      o_cp[k] = bus.CB_CP; o_sa[k] = bus.CB_Send_out_a;
      o_sb[k] = bus.CB_Send_out_b; o_ack[k] = bus.CB_Ack_out;
    end
  endtask

  // Transaction-level reference: a request falling edge seen while free
  // is fired in the cycle after the edge; the first selected-ack falling
  // edge at least two edges later is acknowledged; the element is free
  // again two edges after that.
  task automatic build_model(input int L);
    int  free;
    int  m;
    bit  sel;
    bit  cur;
    bit  prv;
    for (int k = 0; k < L; k++) begin
      x_cp[k] = 1'b0; x_sa[k] = 1'b1; x_sb[k] = 1'b1; x_ack[k] = 1'b1;
    end
    free = 1;
    for (int e = 1; e < L; e++) begin
      if (e >= free && w_send[e-1] == 1'b0 && (e == 1 || w_send[e-2] == 1'b1)) begin
        sel = w_br[e-1];
        x_cp[e] = 1'b1;
        if (sel) x_sb[e] = 1'b0; else x_sa[e] = 1'b0;
        m = -1;
        for (int j = e + 2; j < L; j++) begin
          cur = sel ? w_ab[j-1] : w_aa[j-1];
          prv = sel ? w_ab[j-2] : w_aa[j-2];
          if (m < 0 && cur == 1'b0 && prv == 1'b1) m = j;
        end
        if (m >= 0) begin
          x_ack[m] = 1'b0;
          free = m + 2;
        end else begin
          free = L;
        end
      end
    end
  endtask

  task automatic test_reset();
    MR = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      vectors++;
      if ({bus.CB_CP, bus.CB_Send_out_a, bus.CB_Send_out_b, bus.CB_Ack_out} !== 4'b0111) begin
        miscompares++;
        $display("FAIL reset cyc %0d: cp,sa,sb,ack = %b, required 0111", c,
                 {bus.CB_CP, bus.CB_Send_out_a, bus.CB_Send_out_b, bus.CB_Ack_out});
      end
    end
    @(posedge CLK); #2 MR = 1'b1;
  endtask

  task automatic test_abort();
    @(posedge CLK); #1 send_drv = 1'b0; br_drv = 1'b0;
    @(posedge CLK); #1 send_drv = 1'b1;
    vectors++;
    if ({bus.CB_CP, bus.CB_Send_out_a} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_fire_setup: cp,sa = %b, required 10", {bus.CB_CP, bus.CB_Send_out_a});
    end
    #2 MR = 1'b0;
    #1;
    vectors++;
    if ({bus.CB_CP, bus.CB_Send_out_a, bus.CB_Send_out_b, bus.CB_Ack_out} !== 4'b0111) begin
      miscompares++;
      $display("FAIL abort_fire: cp,sa,sb,ack = %b, required 0111",
               {bus.CB_CP, bus.CB_Send_out_a, bus.CB_Send_out_b, bus.CB_Ack_out});
    end
    @(posedge CLK); #2 MR = 1'b1;
    @(posedge CLK); #1 send_drv = 1'b0;
    @(posedge CLK); #1 send_drv = 1'b1;
    @(posedge CLK); #3 MR = 1'b0;
    #1;
    vectors++;
    if ({bus.CB_CP, bus.CB_Send_out_a, bus.CB_Send_out_b, bus.CB_Ack_out} !== 4'b0111) begin
      miscompares++;
      $display("FAIL abort_wait: cp,sa,sb,ack = %b, required 0111",
               {bus.CB_CP, bus.CB_Send_out_a, bus.CB_Send_out_b, bus.CB_Ack_out});
    end
    aa_drv = 1'b0;
    @(posedge CLK); #1 aa_drv = 1'b1;
    @(posedge CLK); #2 MR = 1'b1;
    @(posedge CLK); #1 aa_drv = 1'b0; ab_drv = 1'b0;
    @(posedge CLK); #1 aa_drv = 1'b1; ab_drv = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      vectors++;
      if ({bus.CB_CP, bus.CB_Ack_out} !== 2'b01) begin
        miscompares++;
        $display("FAIL abort_no_ack cyc %0d: cp,ack = %b, required 01", c, {bus.CB_CP, bus.CB_Ack_out});
      end
    end
  endtask

  task automatic test_reset_release_low();
    @(posedge CLK); #1 MR = 1'b0; send_drv = 1'b0; br_drv = 1'b1;
    @(posedge CLK); #2 MR = 1'b1;
    @(posedge CLK); #1 br_drv = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({bus.CB_CP, bus.CB_Send_out_a, bus.CB_Send_out_b} !== 3'b110) begin
      miscompares++;
      $display("FAIL release_low_fire: cp,sa,sb = %b, required 110",
               {bus.CB_CP, bus.CB_Send_out_a, bus.CB_Send_out_b});
    end
    @(posedge CLK); #1 send_drv = 1'b1;
    @(posedge CLK); #1 ab_drv = 1'b0;
    @(posedge CLK); #1 ab_drv = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus.CB_Ack_out !== 1'b0) begin
      miscompares++;
      $display("FAIL release_low_ack: ack = %b, required 0", bus.CB_Ack_out);
    end
    repeat (3) @(posedge CLK);
  endtask

  task automatic test_route_a();
    clear_wave(16);
    w_send[2] = 1'b0; w_aa[5] = 1'b0;
    apply_window(16); build_model(16);
    vectors++;
    if ({o_cp[3], o_sa[3], o_sb[3], o_ack[6]} !== 4'b1010) begin
      miscompares++;
      $display("FAIL route_a_anchor: cp3,sa3,sb3,ack6 = %b, required 1010",
               {o_cp[3], o_sa[3], o_sb[3], o_ack[6]});
    end
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if ({o_cp[k], o_sa[k], o_sb[k], o_ack[k]} !== {x_cp[k], x_sa[k], x_sb[k], x_ack[k]}) begin
        miscompares++;
        $display("FAIL route_a cyc %0d: cp,sa,sb,ack = %b, required %b", k,
                 {o_cp[k], o_sa[k], o_sb[k], o_ack[k]}, {x_cp[k], x_sa[k], x_sb[k], x_ack[k]});
      end
    end
  endtask

  task automatic test_route_b();
    clear_wave(16);
    for (int k = 0; k < 16; k++) w_br[k] = 1'b1;
    w_send[2] = 1'b0; w_aa[5] = 1'b0; w_ab[8] = 1'b0;
    apply_window(16); build_model(16);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if ({o_cp[k], o_sa[k], o_sb[k], o_ack[k]} !== {x_cp[k], x_sa[k], x_sb[k], x_ack[k]}) begin
        miscompares++;
        $display("FAIL route_b cyc %0d: cp,sa,sb,ack = %b, required %b", k,
                 {o_cp[k], o_sa[k], o_sb[k], o_ack[k]}, {x_cp[k], x_sa[k], x_sb[k], x_ack[k]});
      end
    end
  endtask

  task automatic test_send_in_wait();
    clear_wave(16);
    w_send[2] = 1'b0; w_send[5] = 1'b0; w_aa[8] = 1'b0; w_send[9] = 1'b0;
    apply_window(16); build_model(16);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if ({o_cp[k], o_sa[k], o_sb[k], o_ack[k]} !== {x_cp[k], x_sa[k], x_sb[k], x_ack[k]}) begin
        miscompares++;
        $display("FAIL send_in_wait cyc %0d: cp,sa,sb,ack = %b, required %b", k,
                 {o_cp[k], o_sa[k], o_sb[k], o_ack[k]}, {x_cp[k], x_sa[k], x_sb[k], x_ack[k]});
      end
    end
  endtask

  task automatic test_br_toggle();
    clear_wave(24);
    for (int k = 0; k < 24; k++) w_br[k] = (k < 8) ? (k == 2) : (k != 10);
    w_send[2] = 1'b0; w_ab[5] = 1'b0; w_aa[6] = 1'b0;
    w_send[10] = 1'b0; w_ab[12] = 1'b0; w_aa[13] = 1'b0;
    apply_window(24); build_model(24);
    for (int k = 0; k < 24; k++) begin
      vectors++;
      if ({o_cp[k], o_sa[k], o_sb[k], o_ack[k]} !== {x_cp[k], x_sa[k], x_sb[k], x_ack[k]}) begin
        miscompares++;
        $display("FAIL br_toggle cyc %0d: cp,sa,sb,ack = %b, required %b", k,
                 {o_cp[k], o_sa[k], o_sb[k], o_ack[k]}, {x_cp[k], x_sa[k], x_sb[k], x_ack[k]});
      end
    end
  endtask

  task automatic test_fire_ack();
    clear_wave(16);
    for (int k = 0; k < 16; k++) w_br[k] = 1'b1;
    w_send[2] = 1'b0; w_ab[3] = 1'b0; w_aa[6] = 1'b0; w_ab[6] = 1'b0;
    apply_window(16); build_model(16);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if ({o_cp[k], o_sa[k], o_sb[k], o_ack[k]} !== {x_cp[k], x_sa[k], x_sb[k], x_ack[k]}) begin
        miscompares++;
        $display("FAIL fire_ack cyc %0d: cp,sa,sb,ack = %b, required %b", k,
                 {o_cp[k], o_sa[k], o_sb[k], o_ack[k]}, {x_cp[k], x_sa[k], x_sb[k], x_ack[k]});
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_wave(24);
    for (int i = 0; i < 4; i++) begin
      for (int k = 4 * i; k < 4 * i + 4; k++) w_br[k] = i[0];
      w_send[4 * i + 1] = 1'b0;
      if (i[0]) w_ab[4 * i + 3] = 1'b0; else w_aa[4 * i + 3] = 1'b0;
    end
    apply_window(24); build_model(24);
    for (int k = 0; k < 24; k++) begin
      vectors++;
      if ({o_cp[k], o_sa[k], o_sb[k], o_ack[k]} !== {x_cp[k], x_sa[k], x_sb[k], x_ack[k]}) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: cp,sa,sb,ack = %b, required %b", k,
                 {o_cp[k], o_sa[k], o_sb[k], o_ack[k]}, {x_cp[k], x_sa[k], x_sb[k], x_ack[k]});
      end
    end
  endtask

  task automatic test_random();
    int L;
    L = 64;
    for (int w = 0; w < 40; w++) begin
      for (int k = 0; k < L; k++) begin
        w_br[k] = 1'($urandom_range(0, 1));
        if (k < L - 12) begin
          w_send[k] = ($urandom_range(0, 3) != 0);
          w_aa[k]   = ($urandom_range(0, 4) != 0);
          w_ab[k]   = ($urandom_range(0, 4) != 0);
        end else begin
          w_send[k] = 1'b1; w_aa[k] = 1'b1; w_ab[k] = 1'b1;
        end
      end
      w_aa[L - 10] = 1'b0;
      w_ab[L - 8]  = 1'b0;
      apply_window(L); build_model(L);
      for (int k = 0; k < L; k++) begin
        vectors++;
        if ({o_cp[k], o_sa[k], o_sb[k], o_ack[k]} !== {x_cp[k], x_sa[k], x_sb[k], x_ack[k]}) begin
          miscompares++;
          $display("FAIL random win %0d cyc %0d: cp,sa,sb,ack = %b, required %b", w, k,
                   {o_cp[k], o_sa[k], o_sb[k], o_ack[k]}, {x_cp[k], x_sa[k], x_sb[k], x_ack[k]});
        end
      end
    end
  endtask

  task automatic test_chain();
    int  n_cp, n_oth, n_sack, n_ack, t_sack, t_ack;
    bit  pend_a, pend_b;
    @(posedge CLK); #1 MR = 1'b0; chain_mode = 1'b1; sink_a = 1'b1; sink_b = 1'b1;
    @(posedge CLK); #2 MR = 1'b1;
    for (int b = 0; b < 2; b++) begin
      n_cp = 0; n_oth = 0; n_sack = 0; n_ack = 0; t_sack = -1; t_ack = -1;
      pend_a = 1'b0; pend_b = 1'b0;
      for (int c = 0; c < 16; c++) begin
        @(posedge CLK); #1;
        send_drv = (c == 1) ? 1'b0 : 1'b1;
        br_drv   = b[0];
        sink_a   = !pend_a; sink_b = !pend_b;
        pend_a   = 1'b0; pend_b = 1'b0;
        @(negedge CLK);
        if (sa_send === 1'b0) pend_a = 1'b1;
        if (sb_send === 1'b0) pend_b = 1'b1;
        if ((b[0] ? sb_cp : sa_cp) === 1'b1) n_cp++;
        if ((b[0] ? sa_cp : sb_cp) === 1'b1) n_oth++;
        if ((b[0] ? sb_ack : sa_ack) === 1'b0) begin n_sack++; t_sack = c; end
        if (bus.CB_Ack_out === 1'b0) begin n_ack++; t_ack = c; end
      end
      vectors++;
      if ({n_cp, n_oth, n_sack, n_ack} !== {32'd1, 32'd0, 32'd1, 32'd1}) begin
        miscompares++;
        $display("FAIL chain_counts br=%0d: cp=%0d other_cp=%0d stage_ack=%0d cb_ack=%0d, required 1 0 1 1",
                 b, n_cp, n_oth, n_sack, n_ack);
      end
      vectors++;
      if (t_ack !== 6 || t_sack !== 5) begin
        miscompares++;
        $display("FAIL chain_timing br=%0d: stage_ack cyc %0d cb_ack cyc %0d, required 5 and 6",
                 b, t_sack, t_ack);
      end
    end
    sink_a = 1'b1; sink_b = 1'b1;
    chain_mode = 1'b0;
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    test_reset();
    test_abort();
    test_reset_release_low();
    test_route_a();
    test_route_b();
    test_send_in_wait();
    test_br_toggle();
    test_fire_ack();
    test_back_to_back();
    test_random();
    test_chain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
